// File: rtl/tcr_pkg.sv
// Shared definitions for the toggle-cell register.
// Mode encodings used by the interface, the top and the bench.
package tcr_pkg;

    typedef enum logic [1:0] {
        TCR_HOLD   = 2'b00,
        TCR_LOAD   = 2'b01,
        TCR_TOGGLE = 2'b10,
        TCR_COUNT  = 2'b11
    } tcr_mode_e;

endpackage

// File: rtl/t_cell_register_if.sv
// Control/data bundle of the toggle-cell register.
// master drives controls and observes q/tc/ovf; slave is the register.
interface t_cell_register_if
    import tcr_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             en;
    logic             clr;
    tcr_mode_e        mode;
    logic             dir;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en, clr, mode, dir, d,
        input  q, tc, ovf
    );

    modport slave (
        input  en, clr, mode, dir, d,
        output q, tc, ovf
    );

endinterface

// File: rtl/t_cell_register_t_cell.sv
// One-bit toggle flop: q flips on each edge where t is high.
// INIT is the value forced while reset is low.
module t_cell #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;

    // Toggle storage with asynchronous active-low reset to INIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q_q <= INIT;
        else        q_q <= q_q ^ t;
    end

    assign q = q_q;

endmodule

// File: rtl/t_cell_register.sv
// Multi-mode register built from toggle cells: hold, load,
// masked toggle and modulo up/down count; cells get t = next ^ q.
module t_cell_register
    import tcr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODULUS   = 256,
    parameter bit SATURATE  = 1'b0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    t_cell_register_if.slave bus
);

    // Top count value, kept one bit wider so MODULUS = 2**WIDTH fits
    localparam logic [WIDTH:0]   MAXV    = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RV      = WIDTH'(RESET_VAL);
    localparam logic             TC_INIT = ({1'b0, RV} == MAXV);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] t_w;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   inc_w;
    logic [WIDTH:0]   dec_w;
    logic             ovf_d;
    logic             tc_d;
    logic             ovf_q;
    logic             tc_q;

    assign q_ext = {1'b0, q_w};
    assign inc_w = q_ext + 1'b1;
    assign dec_w = q_ext - 1'b1;

    // Next-state selection; clear beats enable and mode
    always_comb begin
        next_d = q_w;
        ovf_d  = 1'b0;
        if (bus.clr) begin
            next_d = '0;
        end else if (bus.en) begin
            unique case (bus.mode)
                TCR_HOLD:   next_d = q_w;
                TCR_LOAD:   next_d = bus.d;
                TCR_TOGGLE: next_d = q_w ^ bus.d;
                TCR_COUNT: begin
                    if (bus.dir) begin
                        if (q_ext < MAXV) begin
                            next_d = inc_w[WIDTH-1:0];
                        end else if (q_ext == MAXV) begin
                            ovf_d  = 1'b1;
                            next_d = SATURATE ? q_w : '0;
                        end else begin
                            // out-of-range value left by a load
                            ovf_d  = 1'b1;
                            next_d = '0;
                        end
                    end else begin
                        if (q_ext == '0) begin
                            ovf_d  = 1'b1;
                            next_d = SATURATE ? q_w : MAXV[WIDTH-1:0];
                        end else if (q_ext <= MAXV) begin
                            next_d = dec_w[WIDTH-1:0];
                        end else begin
                            ovf_d  = 1'b1;
                            next_d = MAXV[WIDTH-1:0];
                        end
                    end
                end
                default:    next_d = q_w;
            endcase
        end
    end

    // Terminal count describes the value being entered
    always_comb begin
        tc_d = bus.dir ? ({1'b0, next_d} == MAXV) : (next_d == '0);
    end

    assign t_w = next_d ^ q_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_cell #(
            .INIT (RV[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t_w[i]),
            .q     (q_w[i])
        );
    end

    // Status flags registered on the same edge as the cells
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc_q  <= TC_INIT;
            ovf_q <= 1'b0;
        end else begin
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q   = q_w;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_t_cell_register.sv
// Bench for t_cell_register: four parameterisations, directed
// stimulus with expected outputs queued and compared after each edge.
module tb_t_cell_register;
    import tcr_pkg::*;

    typedef struct {
        int         idx;
        string      tag;
        logic [7:0] q;
        logic       tc;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    t_cell_register_if #(.WIDTH(8)) ifa ();
    t_cell_register_if #(.WIDTH(8)) ifb ();
    t_cell_register_if #(.WIDTH(8)) ifc ();
    t_cell_register_if #(.WIDTH(8)) ifd ();

    t_cell_register #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0), .RESET_VAL(5))
        u_a (.clk(clk), .reset(rst), .bus(ifa));
    t_cell_register #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0))
        u_b (.clk(clk), .reset(rst), .bus(ifb));
    t_cell_register #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(0))
        u_c (.clk(clk), .reset(rst), .bus(ifc));
    t_cell_register #(.WIDTH(8), .MODULUS(200), .SATURATE(1'b0), .RESET_VAL(0))
        u_d (.clk(clk), .reset(rst), .bus(ifd));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs(input int idx);
        case (idx)
            0:       return {ifa.q, ifa.tc, ifa.ovf};
            1:       return {ifb.q, ifb.tc, ifb.ovf};
            2:       return {ifc.q, ifc.tc, ifc.ovf};
            default: return {ifd.q, ifd.tc, ifd.ovf};
        endcase
    endfunction

    task automatic pop_check();
        exp_t e;
        logic [9:0] o;
        e = sb.pop_front();
        o = outs(e.idx);
        check({e.tag, ".q"},   32'(o[9:2]), 32'(e.q));
        check({e.tag, ".tc"},  32'(o[1]),   32'(e.tc));
        check({e.tag, ".ovf"}, 32'(o[0]),   32'(e.ovf));
    endtask

    task automatic idle();
        ifa.en = 1'b0; ifa.clr = 1'b0;
        ifb.en = 1'b0; ifb.clr = 1'b0;
        ifc.en = 1'b0; ifc.clr = 1'b0;
        ifd.en = 1'b0; ifd.clr = 1'b0;
    endtask

    task automatic step(input int idx, input string tag,
                        input logic en, input logic clr,
                        input tcr_mode_e mode, input logic dir,
                        input logic [7:0] d, input logic [7:0] eq,
                        input logic etc, input logic eovf);
        exp_t e;
        idle();
        case (idx)
            0: begin ifa.en = en; ifa.clr = clr; ifa.mode = mode;
                     ifa.dir = dir; ifa.d = d; end
            1: begin ifb.en = en; ifb.clr = clr; ifb.mode = mode;
                     ifb.dir = dir; ifb.d = d; end
            2: begin ifc.en = en; ifc.clr = clr; ifc.mode = mode;
                     ifc.dir = dir; ifc.d = d; end
            default: begin ifd.en = en; ifd.clr = clr; ifd.mode = mode;
                     ifd.dir = dir; ifd.d = d; end
        endcase
        e = '{idx: idx, tag: tag, q: eq, tc: etc, ovf: eovf};
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic expect_now(input int idx, input string tag,
                              input logic [7:0] eq, input logic etc,
                              input logic eovf);
        exp_t e;
        e = '{idx: idx, tag: tag, q: eq, tc: etc, ovf: eovf};
        sb.push_back(e);
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.mode = TCR_HOLD; ifa.dir = 1'b1; ifa.d = '0;
        ifb.mode = TCR_HOLD; ifb.dir = 1'b1; ifb.d = '0;
        ifc.mode = TCR_HOLD; ifc.dir = 1'b1; ifc.d = '0;
        ifd.mode = TCR_HOLD; ifd.dir = 1'b1; ifd.d = '0;
        idle();
        // asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        expect_now(0, "rst_a", 8'h05, 1'b0, 1'b0);
        expect_now(1, "rst_b", 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        step(0, "hold",   1, 0, TCR_HOLD,   1, 8'h00, 8'h05, 0, 0);
        step(0, "ld_a5",  1, 0, TCR_LOAD,   1, 8'hA5, 8'hA5, 0, 0);
        step(0, "ld_3c",  1, 0, TCR_LOAD,   1, 8'h3C, 8'h3C, 0, 0);
        step(0, "tog_ff", 1, 0, TCR_TOGGLE, 1, 8'hFF, 8'hC3, 0, 0);
        step(0, "tog_0f", 1, 0, TCR_TOGGLE, 1, 8'h0F, 8'hCC, 0, 0);
        step(0, "ld_ff",  1, 0, TCR_LOAD,   1, 8'hFF, 8'hFF, 1, 0);
        step(0, "up_wrp", 1, 0, TCR_COUNT,  1, 8'h00, 8'h00, 0, 1);
        step(0, "up_1",   1, 0, TCR_COUNT,  1, 8'h00, 8'h01, 0, 0);
        step(0, "clr_ld", 1, 1, TCR_LOAD,   1, 8'h77, 8'h00, 0, 0);
        step(0, "ld_12",  1, 0, TCR_LOAD,   1, 8'h12, 8'h12, 0, 0);
        step(0, "clr_en0",0, 1, TCR_LOAD,   1, 8'h77, 8'h00, 0, 0);
        step(0, "ld_40",  1, 0, TCR_LOAD,   1, 8'h40, 8'h40, 0, 0);
        step(0, "en0_cnt",0, 0, TCR_COUNT,  1, 8'h00, 8'h40, 0, 0);
        step(0, "dn_3f",  1, 0, TCR_COUNT,  0, 8'h00, 8'h3F, 0, 0);
        step(0, "dn_wrp0",1, 0, TCR_LOAD,   0, 8'h00, 8'h00, 1, 0);
        step(0, "dn_wrp", 1, 0, TCR_COUNT,  0, 8'h00, 8'hFF, 0, 1);
        // modulo 10, wrapping
        step(1, "b_ld8",  1, 0, TCR_LOAD,   1, 8'h08, 8'h08, 0, 0);
        step(1, "b_up9",  1, 0, TCR_COUNT,  1, 8'h00, 8'h09, 1, 0);
        step(1, "b_wrp",  1, 0, TCR_COUNT,  1, 8'h00, 8'h00, 0, 1);
        step(1, "b_up1",  1, 0, TCR_COUNT,  1, 8'h00, 8'h01, 0, 0);
        step(1, "b_dn0",  1, 0, TCR_COUNT,  0, 8'h00, 8'h00, 1, 0);
        step(1, "b_dnw",  1, 0, TCR_COUNT,  0, 8'h00, 8'h09, 0, 1);
        step(1, "b_ldc",  1, 0, TCR_LOAD,   0, 8'h0C, 8'h0C, 0, 0);
        step(1, "b_oor",  1, 0, TCR_COUNT,  0, 8'h00, 8'h09, 0, 1);
        // modulo 10, saturating
        step(2, "c_ld1",  1, 0, TCR_LOAD,   0, 8'h01, 8'h01, 0, 0);
        step(2, "c_dn0",  1, 0, TCR_COUNT,  0, 8'h00, 8'h00, 1, 0);
        step(2, "c_blk1", 1, 0, TCR_COUNT,  0, 8'h00, 8'h00, 1, 1);
        step(2, "c_blk2", 1, 0, TCR_COUNT,  0, 8'h00, 8'h00, 1, 1);
        step(2, "c_up1",  1, 0, TCR_COUNT,  1, 8'h00, 8'h01, 0, 0);
        step(2, "c_ld9",  1, 0, TCR_LOAD,   1, 8'h09, 8'h09, 1, 0);
        step(2, "c_blku", 1, 0, TCR_COUNT,  1, 8'h00, 8'h09, 1, 1);
        // modulo 200, count from out-of-range load
        step(3, "d_ldf0", 1, 0, TCR_LOAD,   1, 8'hF0, 8'hF0, 0, 0);
        step(3, "d_oor",  1, 0, TCR_COUNT,  1, 8'h00, 8'h00, 0, 1);
        // reset mid-run with ovf high
        #1 rst = 1'b0;
        #1;
        expect_now(3, "rst2_d", 8'h00, 1'b0, 1'b0);
        expect_now(0, "rst2_a", 8'h05, 1'b0, 1'b0);
        expect_now(2, "rst2_c", 8'h00, 1'b0, 1'b0);
        #1 rst = 1'b1;
        step(3, "d_ldc7", 1, 0, TCR_LOAD,   1, 8'hC7, 8'hC7, 1, 0);
        step(3, "d_wrp",  1, 0, TCR_COUNT,  1, 8'h00, 8'h00, 0, 1);
        step(0, "a_hold", 1, 0, TCR_HOLD,   1, 8'h00, 8'h05, 0, 0);
        if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
